// File: rtl/snes_controller_device_if.sv
// snes_controller_device_if: SNES pad wire bundle (latch, data clock, serial data).
// master is the console/host end; slave is the pad (device) end.
interface snes_controller_device_if;
    logic con_latch;
    logic con_clock;
    logic con_serial;
    modport master(output con_latch, con_clock, input con_serial);
    modport slave(input con_latch, con_clock, output con_serial);
endinterface

// File: rtl/snes_controller_device.sv
// snes_controller_device: SNES pad device end; shifts 16 button bits out on host latch/clock.
// Optional frame-abandon watchdog enabled by defining SNES_DEV_TIMEOUT_EN.
module snes_controller_device #(
    parameter int   SYNC_STAGES    = 2,
    parameter logic IDLE_LEVEL     = 1'b1,
    parameter int   TIMEOUT_CYCLES = 833333
) (
    input  logic                     clock,
    input  logic                     reset,
    snes_controller_device_if.slave  pad,
    input  logic [15:0]              buttons,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     timeout
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] latch_sync, clk_sync;
    logic latch_s, clk_s, latch_s_q, clk_s_q, clk_rise, latch_fall, wd_hit, done_n;
    logic [15:0] sr, sr_n;
    logic [4:0] bit_cnt, cnt_n;
    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign clk_rise   = clk_s & ~clk_s_q;
    assign latch_fall = ~latch_s & latch_s_q;
    assign busy       = state == LOAD || state == SHIFT;
    // host clock idles high, so its synchronizer resets high to avoid a false edge
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            latch_sync     <= '0;
            clk_sync       <= '1;
            latch_s_q      <= 1'b0;
            clk_s_q        <= 1'b1;
            state          <= IDLE;
            sr             <= '0;
            bit_cnt        <= '0;
            pad.con_serial <= IDLE_LEVEL;
            frame_done     <= 1'b0;
        end else begin
            latch_sync     <= {latch_sync[SYNC_STAGES-2:0], pad.con_latch};
            clk_sync       <= {clk_sync[SYNC_STAGES-2:0], pad.con_clock};
            latch_s_q      <= latch_s;
            clk_s_q        <= clk_s;
            state          <= state_n;
            sr             <= sr_n;
            bit_cnt        <= cnt_n;
            pad.con_serial <= (state_n == LOAD || state_n == SHIFT) ? sr_n[15] : IDLE_LEVEL;
            frame_done     <= done_n;
        end
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = bit_cnt;
        done_n  = 1'b0;
        if (latch_s) begin
            state_n = LOAD;
            sr_n    = buttons;
            cnt_n   = '0;
        end else
            case (state)
                LOAD:  state_n = latch_fall ? SHIFT : LOAD;
                SHIFT:
                    if (clk_rise) begin
                        sr_n    = {sr[14:0], IDLE_LEVEL};
                        cnt_n   = bit_cnt + 5'd1;
                        done_n  = bit_cnt == 5'd15;
                        state_n = done_n ? DONE : SHIFT;
                    end else if (wd_hit)
                        state_n = IDLE;
                DONE:  state_n = IDLE;
                default: state_n = state;
            endcase
    end
`ifdef SNES_DEV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd;
    assign wd_hit = state == SHIFT && !clk_rise && wd == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else begin
            wd      <= (state != SHIFT || state_n != SHIFT || clk_rise) ? '0 : wd + 1'b1;
            timeout <= wd_hit && !latch_s;
        end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_snes_controller_device.sv
// tb_snes_controller_device: directed vectors plus corner sequences for the SNES pad device.
// Host half-period is 8 system clocks; data is sampled just before each falling host clock.
module tb_snes_controller_device;
    logic clock, reset;
    logic [15:0] buttons;
    logic frame_done, busy, timeout;
    int total = 0, bad = 0, ndone = 0, ntime = 0;
    snes_controller_device_if pad();
    snes_controller_device #(.SYNC_STAGES(2), .IDLE_LEVEL(1'b1), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .pad(pad), .buttons(buttons),
        .frame_done(frame_done), .busy(busy), .timeout(timeout)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(negedge clock) begin
        if (frame_done) ndone++;
        if (timeout) ntime++;
    end
    typedef struct {
        logic [15:0] b_latch0;
        logic [15:0] b_latch1;
        logic [15:0] b_shift;
        int          nclk;
        logic [15:0] exp_word;
    } vec_t;
    vec_t vecs[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic frame(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                         input int n, output logic [15:0] w, output logic extra_ok, output logic busy_seen);
        w = '0;
        extra_ok = 1'b1;
        buttons = b0;
        pad.con_latch = 1'b1;
        repeat (4) @(negedge clock);
        buttons = b1;
        repeat (4) @(negedge clock);
        pad.con_latch = 1'b0;
        repeat (8) @(negedge clock);
        buttons = b2;
        busy_seen = busy;
        for (int i = 0; i < n; i++) begin
            if (i < 16) w[15-i] = pad.con_serial;
            else if (pad.con_serial !== 1'b1) extra_ok = 1'b0;
            pad.con_clock = 1'b0;
            repeat (8) @(negedge clock);
            pad.con_clock = 1'b1;
            repeat (8) @(negedge clock);
        end
    endtask
    logic [15:0] w;
    logic ex, bs, quiet;
    int d0, t0, cyc;
    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hA5C3, 16, 16'hA5C3};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16, 16'hFFFF};
        vecs[2] = '{16'hA5C3, 16'hA5C3, 16'h1234, 16, 16'hA5C3};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000, 20, 16'hFFFF};
        vecs[4] = '{16'h0001, 16'h0001, 16'h0001, 16, 16'h0001};
        vecs[5] = '{16'h8000, 16'h8000, 16'hFFFF, 16, 16'h8000};
        vecs[6] = '{16'hFFFF, 16'h1234, 16'h0000, 16, 16'h1234};
        reset = 1'b0;
        buttons = '0;
        pad.con_latch = 1'b0;
        pad.con_clock = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_serial", {31'd0, pad.con_serial}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, frame_done}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        foreach (vecs[k]) begin
            d0 = ndone;
            frame(vecs[k].b_latch0, vecs[k].b_latch1, vecs[k].b_shift, vecs[k].nclk, w, ex, bs);
            chk($sformatf("v%0d_word", k), {16'd0, w}, {16'd0, vecs[k].exp_word});
            chk($sformatf("v%0d_busy_in", k), {31'd0, bs}, 32'd1);
            chk($sformatf("v%0d_done_cnt", k), ndone - d0, 32'd1);
            chk($sformatf("v%0d_extra_idle", k), {31'd0, ex}, 32'd1);
            chk($sformatf("v%0d_busy_after", k), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_serial_after", k), {31'd0, pad.con_serial}, 32'd1);
        end
        // aborted frame after 7 clocks, then a fresh latch restarts from bit 15
        d0 = ndone;
        frame(16'h1111, 16'h1111, 16'h1111, 7, w, ex, bs);
        chk("abort_no_done", ndone - d0, 32'd0);
        chk("abort_still_busy", {31'd0, busy}, 32'd1);
        frame(16'hC0DE, 16'hC0DE, 16'hC0DE, 16, w, ex, bs);
        chk("restart_word", {16'd0, w}, 32'h0000C0DE);
        chk("restart_done_cnt", ndone - d0, 32'd1);
        // reset mid-frame at bit 9, then clocks without latch must do nothing
        d0 = ndone;
        frame(16'h0F0F, 16'h0F0F, 16'h0F0F, 9, w, ex, bs);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_serial", {31'd0, pad.con_serial}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pad.con_clock = 1'b0;
            repeat (8) begin
                @(negedge clock);
                if (busy || pad.con_serial !== 1'b1) quiet = 1'b0;
            end
            pad.con_clock = 1'b1;
            repeat (8) begin
                @(negedge clock);
                if (busy || pad.con_serial !== 1'b1) quiet = 1'b0;
            end
        end
        chk("midreset_quiet", {31'd0, quiet}, 32'd1);
        chk("midreset_no_done", ndone - d0, 32'd0);
        // 3 clocks then silence
        d0 = ndone;
        t0 = ntime;
        frame(16'h5555, 16'h5555, 16'h5555, 3, w, ex, bs);
        cyc = 0;
`ifdef SNES_DEV_TIMEOUT_EN
        while (ntime == t0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("wd_pulse_cnt", ntime - t0, 32'd1);
        chk("wd_latency_ok", {31'd0, cyc >= 90 && cyc <= 100}, 32'd1);
        repeat (2) @(negedge clock);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        chk("wd_serial", {31'd0, pad.con_serial}, 32'd1);
`else
        repeat (300) @(negedge clock);
        chk("nowd_still_busy", {31'd0, busy}, 32'd1);
        chk("nowd_no_timeout", ntime - t0, 32'd0);
`endif
        chk("silence_no_done", ndone - d0, 32'd0);
        frame(16'h1234, 16'h1234, 16'h1234, 16, w, ex, bs);
        chk("recover_word", {16'd0, w}, 32'h00001234);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
